// File: rtl/usr_seq_pkg.sv
// usr_seq_pkg: shared definitions for the USR sequencer.
//   MODE_*  : USR mode encodings (hold / shift right / shift left / load)
//   ID_*    : requester identifiers used for grant and done_id
//   state_t : sequencer FSM states
package usr_seq_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/usr_seq_rr_arb.sv
// usr_seq_rr_arb: 2-way round-robin arbiter with a 1-bit priority pointer.
//   clk, rst  : clock, asynchronous active-high reset (pointer favours A)
//   valids    : request lines, bit 0 = A, bit 1 = B
//   advance   : a grant was taken this cycle; priority passes to the other side
//   grant     : one-hot grant (zero when nobody requests)
//   grant_id  : index of the granted requester
module usr_seq_rr_arb
    import usr_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valids,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    logic ptr;

    // The pointer only matters on contention; a lone requester always wins.
    always_comb begin
        grant_id = ID_A;
        if (valids[0] && valids[1]) begin
            grant_id = ptr;
        end else if (valids[1]) begin
            grant_id = ID_B;
        end
        grant = '0;
        if (valids != 2'b00) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= ID_A;
        end else if (advance) begin
            ptr <= ~grant_id;
        end
    end

endmodule

// File: rtl/usr_sequencer.sv
// usr_sequencer: two-requester front end that drives an 8-bit universal shift
// register as a parallel-to-serial converter.
//   clk, rst                        : clock, asynchronous active-high reset
//   a_valid/a_ready/a_data/a_dir    : requester A word handshake (dir 1 = MSB first)
//   b_valid/b_ready/b_data/b_dir    : requester B, same as A
//   usr_mode/usr_pdata/usr_sil/usr_sir : USR control, parallel data, serial fills
//   usr_q                           : current USR contents
//   ser_bit/ser_valid/ser_ready/ser_last : outgoing serial beat handshake
//   done/done_id                    : one-cycle completion pulse and its requester
//   busy                            : high whenever not IDLE
// Build option: USR_SEQ_ROTATE_EN makes the vacated end take the outgoing bit
// (rotate); otherwise FILL_BIT is shifted in.
module usr_sequencer
    import usr_seq_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_dir,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_dir,
    output logic [1:0]       usr_mode,
    output logic [WIDTH-1:0] usr_pdata,
    output logic             usr_sil,
    output logic             usr_sir,
    input  logic [WIDTH-1:0] usr_q,
    output logic             ser_bit,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done,
    output logic             done_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] word;
    logic             dir_q;
    logic             id_q;
    logic [CW-1:0]    count;

    logic [1:0]       grant;
    logic             grant_id;
    logic             idle;
    logic             accept;
    logic             last;
    logic             out_bit;
    logic             fill;

    // rst is folded in so readies read 0 while reset is held, not just after.
    assign idle    = (state == ST_IDLE) && !rst;
    assign a_ready = idle && grant[0];
    assign b_ready = idle && grant[1];
    assign accept  = a_ready || b_ready;
    assign last    = (count == CW'(WIDTH - 1));
    assign out_bit = dir_q ? usr_q[WIDTH-1] : usr_q[0];

`ifdef USR_SEQ_ROTATE_EN
    assign fill = out_bit;
`else
    assign fill = FILL_BIT;
`endif

    usr_seq_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .valids   ({b_valid, a_valid}),
        .advance  (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            word  <= '0;
            dir_q <= 1'b0;
            id_q  <= ID_A;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        word  <= (grant_id == ID_B) ? b_data : a_data;
                        dir_q <= (grant_id == ID_B) ? b_dir  : a_dir;
                        id_q  <= grant_id;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // The count stops at WIDTH-1; the last beat leaves instead.
                    if (ser_ready) begin
                        if (last) begin
                            state <= ST_DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state; only the shift mode also follows
    // ser_ready so a stalled beat holds the USR.
    always_comb begin
        usr_mode  = MODE_HOLD;
        usr_pdata = '0;
        usr_sil   = 1'b0;
        usr_sir   = 1'b0;
        ser_bit   = 1'b0;
        ser_valid = 1'b0;
        ser_last  = 1'b0;
        done      = 1'b0;
        done_id   = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_LOAD: begin
                usr_mode  = MODE_LOAD;
                usr_pdata = word;
                busy      = 1'b1;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_bit   = out_bit;
                ser_last  = last;
                if (dir_q) begin
                    usr_sir = fill;
                end else begin
                    usr_sil = fill;
                end
                if (ser_ready) begin
                    usr_mode = dir_q ? MODE_SHL : MODE_SHR;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                done_id = id_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// tb_usr_sequencer: directed bench for usr_sequencer with a behavioural USR
// model and a transaction scoreboard. Built with FILL_BIT = 1; the expected
// final USR contents follow USR_SEQ_ROTATE_EN.
module tb_usr_sequencer;
    import usr_seq_pkg::*;

    localparam int W = 8;
`ifdef USR_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, a_ready, a_dir;
    logic [W-1:0] a_data;
    logic         b_valid, b_ready, b_dir;
    logic [W-1:0] b_data;
    logic [1:0]   usr_mode;
    logic [W-1:0] usr_pdata;
    logic         usr_sil, usr_sir;
    logic [W-1:0] usr_q;
    logic         ser_bit, ser_valid, ser_ready, ser_last;
    logic         done, done_id, busy;

    usr_sequencer #(.WIDTH(W), .FILL_BIT(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_dir     (a_dir),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_dir     (b_dir),
        .usr_mode  (usr_mode),
        .usr_pdata (usr_pdata),
        .usr_sil   (usr_sil),
        .usr_sir   (usr_sir),
        .usr_q     (usr_q),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .done      (done),
        .done_id   (done_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register.
    always @(posedge clk) begin
        case (usr_mode)
            2'b01:   usr_q <= {usr_sil, usr_q[W-1:1]};
            2'b10:   usr_q <= {usr_q[W-2:0], usr_sir};
            2'b11:   usr_q <= usr_pdata;
            default: usr_q <= usr_q;
        endcase
    end

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         dir;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    bit   active, just_acc, have_prev, check_gap;
    logic last_acc_id;
    int   bitidx, stalls, t0, prev_t0, cyc, n_done;
    int   checks, errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit();
        int idx;
        idx = (bitidx < W) ? bitidx : W - 1;
        return cur.dir ? cur.data[W-1-idx] : cur.data[idx];
    endfunction

    // Runs at the falling edge, mid-cycle, against the scoreboard head.
    task automatic monitor();
        logic eb, fl;
        if (busy) chk("ready_while_busy", {a_ready, b_ready}, 0);
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
            chk("single_grant", {31'd0, a_ready & b_ready}, 0);
            chk("accept_expected", {31'd0, exp_q.size() > 0}, 1);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                chk("grant_id", {31'd0, b_ready}, {31'd0, cur.id});
                if (check_gap && have_prev) chk("b2b_gap", cyc - prev_t0, W + 3);
                have_prev   = 1'b1;
                prev_t0     = cyc;
                last_acc_id = b_ready;
                just_acc    = 1'b1;
                active      = 1'b1;
                bitidx      = 0;
                stalls      = 0;
                t0          = cyc;
            end
        end
        if (usr_mode == MODE_LOAD) begin
            chk("load_pdata", usr_pdata, cur.data);
            chk("load_latency", cyc - t0, 1);
        end
        if (ser_valid) begin
            chk("beat_in_range", {31'd0, bitidx < W}, 1);
            eb = exp_bit();
            fl = ROT ? eb : 1'b1;
            chk("ser_bit", ser_bit, eb);
            chk("usr_sil", usr_sil, cur.dir ? 1'b0 : fl);
            chk("usr_sir", usr_sir, cur.dir ? fl : 1'b0);
            if (ser_ready) begin
                chk("mode_shift", usr_mode, cur.dir ? MODE_SHL : MODE_SHR);
                chk("ser_last", ser_last, bitidx == W - 1);
                bitidx++;
            end else begin
                chk("mode_stall", usr_mode, MODE_HOLD);
                stalls++;
            end
        end
        if (done) begin
            chk("done_expected", {31'd0, active}, 1);
            chk("done_id", done_id, cur.id);
            chk("beats", bitidx, W);
            chk("done_latency", cyc - t0, W + 2 + stalls);
            chk("usr_q_final", usr_q, ROT ? cur.data : {W{1'b1}});
            active = 1'b0;
            n_done++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push(input logic id, input logic [W-1:0] data, input logic dir);
        txn_t t;
        t.id = id; t.data = data; t.dir = dir;
        exp_q.push_back(t);
    endtask

    // Steps until every queued word has completed (or the abort beat is reached).
    task automatic run(input bit keep, input int stall_at, input int stall_len,
                       input int abort_at);
        int rem;
        bit fin;
        rem = stall_len;
        fin = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (abort_at >= 0 && active && ser_valid && bitidx == abort_at) begin
                fin = 1'b1;
                break;
            end
            if (active && ser_valid && bitidx == stall_at && rem > 0) begin
                ser_ready = 1'b0;
                rem--;
            end else begin
                ser_ready = 1'b1;
            end
            step();
            if (just_acc) begin
                just_acc = 1'b0;
                if (exp_q.size() == 0) begin
                    a_valid = 1'b0;
                    b_valid = 1'b0;
                end else if (!keep) begin
                    if (last_acc_id) b_valid = 1'b0;
                    else a_valid = 1'b0;
                end
            end
            if (exp_q.size() == 0 && !active && !a_valid && !b_valid) begin
                fin = 1'b1;
                break;
            end
        end
        ser_ready = 1'b1;
        chk("run_finished", {31'd0, fin}, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, {a_ready, b_ready, usr_mode, usr_pdata, usr_sil, usr_sir, ser_bit,
                  ser_valid, ser_last, done, done_id, busy}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset_outputs");
        active = 1'b0;
        have_prev = 1'b0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int d0;
        checks = 0; errors = 0; cyc = 0; n_done = 0;
        active = 1'b0; just_acc = 1'b0; have_prev = 1'b0; check_gap = 1'b0;
        a_valid = 1'b0; a_data = '0; a_dir = 1'b0;
        b_valid = 1'b0; b_data = '0; b_dir = 1'b0;
        ser_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_all_zero("reset_state");
        do_reset();

        // 1: A, 0x0D, LSB first.
        push(ID_A, 8'h0D, 1'b0);
        a_data = 8'h0D; a_dir = 1'b0; a_valid = 1'b1;
        run(1'b0, -1, 0, -1);

        // 2: B, 0xA5, MSB first.
        push(ID_B, 8'hA5, 1'b1);
        b_data = 8'hA5; b_dir = 1'b1; b_valid = 1'b1;
        run(1'b0, -1, 0, -1);

        // 3: both requesting continuously from reset -> A, B, A, B back to back.
        do_reset();
        d0 = n_done;
        check_gap = 1'b1;
        push(ID_A, 8'h5C, 1'b0);
        push(ID_B, 8'h93, 1'b1);
        push(ID_A, 8'h5C, 1'b0);
        push(ID_B, 8'h93, 1'b1);
        a_data = 8'h5C; a_dir = 1'b0; a_valid = 1'b1;
        b_data = 8'h93; b_dir = 1'b1; b_valid = 1'b1;
        run(1'b1, -1, 0, -1);
        check_gap = 1'b0;
        chk("alt_done_count", n_done - d0, 4);

        // 4: three-cycle stall after beat 4.
        push(ID_A, 8'h0D, 1'b0);
        a_data = 8'h0D; a_dir = 1'b0; a_valid = 1'b1;
        run(1'b0, 4, 3, -1);

        // 5: reset during beat 5 (A accepted so pointer favours B), then both
        // request and A must win first.
        push(ID_A, 8'hE7, 1'b0);
        a_data = 8'hE7; a_dir = 1'b0; a_valid = 1'b1;
        run(1'b0, -1, 0, 4);
        d0 = n_done;
        do_reset();
        chk("no_done_after_abort", n_done - d0, 0);
        push(ID_A, 8'h3C, 1'b0);
        push(ID_B, 8'h81, 1'b1);
        a_data = 8'h3C; a_dir = 1'b0; a_valid = 1'b1;
        b_data = 8'h81; b_dir = 1'b1; b_valid = 1'b1;
        run(1'b0, -1, 0, -1);

        // 6: 0x96 both directions; final usr_q checked at each done.
        push(ID_A, 8'h96, 1'b0);
        a_data = 8'h96; a_dir = 1'b0; a_valid = 1'b1;
        run(1'b0, -1, 0, -1);
        push(ID_B, 8'h96, 1'b1);
        b_data = 8'h96; b_dir = 1'b1; b_valid = 1'b1;
        run(1'b0, -1, 0, -1);
        step();
        chk("idle_after_all", {30'd0, busy, done}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_sequencer.md
# usr_sequencer

Two-requester controller that owns the 8-bit universal shift register (USR) and uses it as a parallel-to-serial converter. Each requester hands over a word with a direction flag. The sequencer arbitrates between them round-robin, loads the word into the USR, and then clocks it out one bit per accepted serial beat. It sits between the request sources and the USR, and is the only driver of the USR mode, parallel-data and serial-fill inputs.

## Interface
- WIDTH, 8, USR width and number of shift beats per word
- FILL_BIT, 1'b0, bit shifted into the vacated end when rotate is not compiled in

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A offers a word
- a_ready  out  1  A's word accepted this cycle
- a_data  in  WIDTH  A's word
- a_dir  in  1  0 = shift right (LSB first), 1 = shift left (MSB first)
- b_valid, b_ready, b_data, b_dir  same as A, for requester B
- usr_mode  out  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- usr_pdata  out  WIDTH  USR parallel input
- usr_sil  out  1  USR serial input used on right shift
- usr_sir  out  1  USR serial input used on left shift
- usr_q  in  WIDTH  current USR contents
- ser_bit  out  1  current outgoing bit
- ser_valid  out  1  ser_bit valid
- ser_ready  in  1  consumer takes ser_bit
- ser_last  out  1  final beat of the word
- done  out  1  one-cycle completion pulse
- done_id  out  1  requester of the completed word (0 = A, 1 = B)
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- **IDLE:** usr_mode = 00.
  - The arbiter grants one valid requester and raises only that requester's ready. Ready may depend combinationally on valid.
  - On a handshake, the sequencer latches data, dir and id, then moves to LOAD.
- **Arbitration:** round-robin with a 1-bit priority pointer.
  - Reset favours A.
  - After a grant, priority passes to the other requester.
  - A lone valid requester is always granted.
- **LOAD:** one cycle. usr_mode = 11, usr_pdata = latched word. Next state is SHIFT with beat count = 0.
- **SHIFT:**
  - ser_valid = 1.
  - ser_bit = usr_q[0] when dir = 0, usr_q[WIDTH-1] when dir = 1.
  - When ser_ready = 1: usr_mode = 01 or 10 per dir and the count increments.
  - When ser_ready = 0: usr_mode = 00 and the count holds.
  - ser_last = (count == WIDTH-1).
  - Leaving SHIFT: a handshake with ser_last set moves to DONE.
- **DONE:** one cycle. usr_mode = 00, done = 1, done_id = latched id. Next state is IDLE.
- **Fill:** on a right shift usr_sil = fill and usr_sir = 0; on a left shift usr_sir = fill and usr_sil = 0. Both are 0 outside SHIFT.
- usr_pdata is 0 outside LOAD.
- The count is $clog2(WIDTH+1) bits wide and never wraps within a word.
- Requests arriving while busy wait; their ready stays low.

## Timing
- **Reset:** asserting rst at any time, including mid-SHIFT, immediately forces:
  - state to IDLE and the priority pointer to A;
  - every output to 0 (usr_mode 00, all readies, ser_*, done, done_id, busy, usr_pdata, fills).
  - The partial word is dropped and no done is issued for it.
- **Latency:** the accept edge is at cycle 0.
  - LOAD is cycle 1.
  - SHIFT occupies cycles 2..WIDTH+1 with no stall.
  - done is high in cycle WIDTH+2.
  - The next accept is possible in cycle WIDTH+3.
  - Each stalled ser_ready cycle adds exactly one cycle.
- ser_bit is stable while ser_valid && !ser_ready.

## Configuration
- USR_SEQ_ROTATE_EN defined: fill = ser_bit, so the register rotates and usr_q equals the loaded word again after done.
- USR_SEQ_ROTATE_EN undefined: fill = FILL_BIT, and after done usr_q = {WIDTH{FILL_BIT}}.

## Structure
- Package usr_seq_pkg holds:
  - mode constants MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11;
  - the state enum;
  - the requester-id constants.
- Sub-module usr_seq_rr_arb: 2-way round-robin arbiter with inputs valids and advance, and outputs grant one-hot and grant id. It owns the priority pointer.

## Test plan
The bench includes a behavioural USR model driven by usr_mode, usr_pdata, usr_sil and usr_sir.

1. A sends 0x0D with dir = 0 and ser_ready = 1 → LOAD with pdata 0x0D; ser_bit sequence 1,0,1,1,0,0,0,0; ser_last on beat 8; done with done_id = 0 exactly WIDTH+2 cycles after accept.
2. B sends 0xA5 with dir = 1 → ser_bit sequence 1,0,1,0,0,1,0,1; usr_mode = 10 on each beat; done_id = 1.
3. A and B both valid continuously from reset → grants alternate A, B, A, B; each done_id matches.
4. Send 0x0D with ser_ready low for 3 cycles after beat 4 → usr_mode = 00 and ser_bit held during the stall; exactly 8 bits delivered; done arrives 3 cycles late.
5. Assert rst during beat 5 → all outputs 0 immediately, no done. After release, A sending 0x3C completes normally with A granted first.
6. With USR_SEQ_ROTATE_EN, 0x96 → usr_q = 0x96 after done. Without it, FILL_BIT = 1 → usr_q = 0xFF.
